resize_sequencer: RTL and testbench
===================================

RESIZE_SEQUENCER -- requirements
Module: resize_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of cycles a key must be stable before it is accepted (20 ms at 50 MHz).
REQ-002 Parameter MAX_LEVEL, default 2, is the maximum zoom level; the scale factor is 2^level.
REQ-003 Parameter TIMEOUT_CYCLES, default 2000000, is the maximum number of cycles the engine may run per job.
REQ-004 clk  in  1  system clock (50 MHz).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 zoom_in_select  in  1  raw switch, asynchronous to clk.
REQ-007 zoom_out_select  in  1  raw switch, asynchronous to clk.
REQ-008 use_block_avg_select  in  1  raw switch, asynchronous to clk.
REQ-009 key_up_n  in  1  active-low button that increments the level.
REQ-010 key_down_n  in  1  active-low button that decrements the level.
REQ-011 frame_start  in  1  one-cycle pulse at the start of vertical blank.
REQ-012 engine_start  out  1  one-cycle pulse that starts a resize job.
REQ-013 engine_mode  out  2  mode of the job being started.
REQ-014 engine_level  out  2  level of the job being started.
REQ-015 engine_done  in  1  one-cycle pulse marking job completion.
REQ-016 display_mode  out  2  committed mode used by the pixel path.
REQ-017 display_level  out  2  committed level.
REQ-018 mode_change_pending  out  1  high while the requested configuration differs from the committed one.
REQ-019 error_timeout  out  1  sticky flag set when an engine job times out.

Function
REQ-020 The three switches SHALL each pass through a 2-flop synchronizer before use.
REQ-021 Mode decode SHALL apply in this priority order:
- zoom_in and zoom_out both set -> PASS (0).
- zoom_in -> ZOOM_IN (1).
- zoom_out and avg -> ZOOM_OUT_AVG (3).
- zoom_out -> ZOOM_OUT_DEC (2).
- otherwise -> PASS.
REQ-022 Each key SHALL be synchronized and debounced, and SHALL produce a one-cycle press pulse when its debounced level falls.
REQ-023 The requested level SHALL saturate within 1..MAX_LEVEL.
REQ-024 Up and down press pulses in the same cycle SHALL leave the level unchanged.
REQ-025 The FSM SHALL have the states IDLE, WAIT_FRAME, START, RUN and COMMIT.
REQ-026 IDLE SHALL go to WAIT_FRAME when the requested {mode, level} differs from the display configuration; mode_change_pending SHALL be high from that transition until COMMIT.
REQ-027 In WAIT_FRAME, a frame_start pulse SHALL snapshot the requested {mode, level} into engine_mode and engine_level.
- Snapshot mode PASS -> COMMIT.
- Any other snapshot mode -> START.
REQ-028 START SHALL assert engine_start for exactly one cycle, namely the cycle after frame_start, and then go to RUN.
REQ-029 RUN SHALL go to COMMIT on engine_done.
REQ-030 RUN SHALL count cycles; at TIMEOUT_CYCLES it SHALL set error_timeout, leave display_* unchanged and go to IDLE, which retries on the next frame.
REQ-031 COMMIT SHALL load display_* from the snapshot, visible in the cycle after engine_done, and go to IDLE.
REQ-032 Request changes during START, RUN or COMMIT SHALL NOT alter the snapshot; IDLE re-evaluates them afterwards.
REQ-033 engine_done outside RUN SHALL be ignored.
REQ-034 frame_start outside WAIT_FRAME SHALL be ignored.
REQ-035 If the request returns to the display value while in WAIT_FRAME, the FSM SHALL go to IDLE and clear mode_change_pending.

Reset
REQ-036 Reset SHALL force the following, regardless of the current state:
- FSM -> IDLE.
- engine_start = 0, engine_mode = PASS, engine_level = 1.
- display_mode = PASS, display_level = 1.
- Requested level = 1.
- mode_change_pending = 0, error_timeout = 0.
- Debounce and timeout counters cleared.
REQ-037 Reset asserted mid-RUN SHALL abandon the job without issuing a further engine_start.

Structure
REQ-038 Package resize_pkg SHALL hold the mode encodings (PASS, ZOOM_IN, ZOOM_OUT_DEC, ZOOM_OUT_AVG), the FSM state enum, and the mode and level width constants.
REQ-039 Sub-module key_debouncer (synchronizer, stability counter and press-pulse output) SHALL be instantiated twice.

Verification
REQ-040 Set zoom_in_select = 1 after reset, then pulse frame_start -> engine_start one cycle later with engine_mode = 1 and engine_level = 1; engine_done -> display_mode = 1 in the next cycle and pending = 0.
REQ-041 Set zoom_in_select and zoom_out_select both to 1 -> no engine_start on frame_start, and display_mode remains 0.
REQ-042 Press key_up_n three times with MAX_LEVEL = 2 (DEBOUNCE_CYCLES = 4 in the bench) -> requested level 2; a 2-cycle glitch produces no increment.
REQ-043 Change the switches to ZOOM_OUT_AVG during RUN -> the first commit uses the snapshot, and a second job starts on the next frame_start with engine_mode = 3.
REQ-044 Withhold engine_done with TIMEOUT_CYCLES = 50 -> error_timeout = 1 at cycle 50, display unchanged, and a retry engine_start on the next frame_start.
REQ-045 Assert reset mid-RUN, then inject engine_done -> all outputs at their reset values and no COMMIT.

Source files
------------

// File: rtl/resize_pkg.sv
// ----------------------------------------------------------------------------
// resize_pkg
// Shared definitions for the resize sequencer: the engine mode encodings,
// the sequencer FSM state set, the mode/level widths and the switch-to-mode
// decode used by the pixel-path controller.
// ----------------------------------------------------------------------------
package resize_pkg;

    localparam int MODE_W  = 2;
    localparam int LEVEL_W = 2;

    typedef enum logic [MODE_W-1:0] {
        PASS         = 2'd0,
        ZOOM_IN      = 2'd1,
        ZOOM_OUT_DEC = 2'd2,
        ZOOM_OUT_AVG = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        START      = 3'd2,
        RUN        = 3'd3,
        COMMIT     = 3'd4
    } state_e;

    // Conflicting zoom switches fall back to pass-through; averaging only
    // matters when shrinking the image.
    function automatic mode_e decode_mode(input logic zoom_in,
                                          input logic zoom_out,
                                          input logic use_avg);
        mode_e m;
        if (zoom_in && zoom_out) begin
            m = PASS;
        end else if (zoom_in) begin
            m = ZOOM_IN;
        end else if (zoom_out && use_avg) begin
            m = ZOOM_OUT_AVG;
        end else if (zoom_out) begin
            m = ZOOM_OUT_DEC;
        end else begin
            m = PASS;
        end
        return m;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// ----------------------------------------------------------------------------
// key_debouncer
// Synchronizes one raw active-low push button, accepts a new level only after
// it has been stable for DEBOUNCE_CYCLES consecutive cycles, and emits a
// one-cycle press pulse when the accepted level falls (button pressed).
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   key_n_i  in   raw active-low button, asynchronous to clk
//   press_o  out  one-cycle pulse per accepted press
// ----------------------------------------------------------------------------
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // The counter measures how long the synchronized key has disagreed with
    // the accepted level; any agreement restarts the measurement, so short
    // glitches never reach the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = stable_q & ~stable_d;
    end

    // Released (high) is the idle level of the button, so the synchronizer
    // and accepted level come out of reset high to avoid a spurious press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], key_n_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/resize_sequencer.sv
// ----------------------------------------------------------------------------
// resize_sequencer
// Turns user switches and zoom keys into a requested {mode, level}, and
// sequences resize-engine jobs so the displayed configuration only changes on
// a frame boundary after the engine has finished.
//
// Ports:
//   clk                   in   system clock
//   reset                 in   synchronous, active-high reset
//   zoom_in_select        in   raw switch
//   zoom_out_select       in   raw switch
//   use_block_avg_select  in   raw switch
//   key_up_n              in   active-low button, level + 1
//   key_down_n            in   active-low button, level - 1
//   frame_start           in   one-cycle pulse at vertical blank
//   engine_start          out  one-cycle job start pulse
//   engine_mode           out  mode of the job being started
//   engine_level          out  level of the job being started
//   engine_done           in   one-cycle job completion pulse
//   display_mode          out  committed mode for the pixel path
//   display_level         out  committed level
//   mode_change_pending   out  request differs from committed configuration
//   error_timeout         out  sticky engine timeout flag
// ----------------------------------------------------------------------------
module resize_sequencer
    import resize_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_LEVEL       = 2,
    parameter int TIMEOUT_CYCLES  = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               zoom_in_select,
    input  logic               zoom_out_select,
    input  logic               use_block_avg_select,
    input  logic               key_up_n,
    input  logic               key_down_n,
    input  logic               frame_start,
    output logic               engine_start,
    output logic [MODE_W-1:0]  engine_mode,
    output logic [LEVEL_W-1:0] engine_level,
    input  logic               engine_done,
    output logic [MODE_W-1:0]  display_mode,
    output logic [LEVEL_W-1:0] display_level,
    output logic               mode_change_pending,
    output logic               error_timeout
);

    localparam logic [LEVEL_W-1:0] MIN_LVL = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         sw_meta_q;
    logic [2:0]         sw_sync_q;
    logic               up_press;
    logic               down_press;
    mode_e              req_mode;
    logic [LEVEL_W-1:0] req_level_q;
    logic [LEVEL_W-1:0] req_level_d;
    logic               req_differs;

    state_e             state_q;
    state_e             state_d;
    mode_e              eng_mode_q;
    mode_e              eng_mode_d;
    logic [LEVEL_W-1:0] eng_level_q;
    logic [LEVEL_W-1:0] eng_level_d;
    mode_e              disp_mode_q;
    mode_e              disp_mode_d;
    logic [LEVEL_W-1:0] disp_level_q;
    logic [LEVEL_W-1:0] disp_level_d;
    logic               pending_q;
    logic               pending_d;
    logic               error_q;
    logic               error_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_up (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_up_n),
        .press_o (up_press)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_down (
        .clk     (clk),
        .reset   (reset),
        .key_n_i (key_down_n),
        .press_o (down_press)
    );

    // Two-flop synchronizer for the switch bank: {avg, zoom_out, zoom_in}.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= {use_block_avg_select, zoom_out_select, zoom_in_select};
            sw_sync_q <= sw_meta_q;
        end
    end

    assign req_mode = decode_mode(sw_sync_q[0], sw_sync_q[1], sw_sync_q[2]);

    // Simultaneous up and down presses cancel; otherwise the level saturates
    // at both ends rather than wrapping.
    always_comb begin
        req_level_d = req_level_q;
        if (up_press && !down_press && (req_level_q < MAX_LVL)) begin
            req_level_d = req_level_q + LEVEL_W'(1);
        end else if (down_press && !up_press && (req_level_q > MIN_LVL)) begin
            req_level_d = req_level_q - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_level_q <= MIN_LVL;
        end else begin
            req_level_q <= req_level_d;
        end
    end

    assign req_differs = (req_mode != disp_mode_q) || (req_level_q != disp_level_q);

    // Sequencer next-state logic. The display registers are loaded on the
    // transition into COMMIT so the new configuration is visible in the cycle
    // right after engine_done (or after frame_start for a pass-through job).
    always_comb begin
        state_d      = state_q;
        eng_mode_d   = eng_mode_q;
        eng_level_d  = eng_level_q;
        disp_mode_d  = disp_mode_q;
        disp_level_d = disp_level_q;
        pending_d    = pending_q;
        error_d      = error_q;
        timer_d      = timer_q;
        engine_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (req_differs) begin
                    state_d   = WAIT_FRAME;
                    pending_d = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (!req_differs) begin
                    state_d   = IDLE;
                    pending_d = 1'b0;
                end else if (frame_start) begin
                    eng_mode_d  = req_mode;
                    eng_level_d = req_level_q;
                    if (req_mode == PASS) begin
                        disp_mode_d  = req_mode;
                        disp_level_d = req_level_q;
                        pending_d    = 1'b0;
                        state_d      = COMMIT;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: begin
                engine_start = 1'b1;
                timer_d      = '0;
                state_d      = RUN;
            end
            RUN: begin
                if (engine_done) begin
                    disp_mode_d  = eng_mode_q;
                    disp_level_d = eng_level_q;
                    pending_d    = 1'b0;
                    state_d      = COMMIT;
                end else if (timer_q == TMR_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and committed configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            eng_mode_q   <= PASS;
            eng_level_q  <= MIN_LVL;
            disp_mode_q  <= PASS;
            disp_level_q <= MIN_LVL;
            pending_q    <= 1'b0;
            error_q      <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            eng_mode_q   <= eng_mode_d;
            eng_level_q  <= eng_level_d;
            disp_mode_q  <= disp_mode_d;
            disp_level_q <= disp_level_d;
            pending_q    <= pending_d;
            error_q      <= error_d;
            timer_q      <= timer_d;
        end
    end

    assign engine_mode         = eng_mode_q;
    assign engine_level        = eng_level_q;
    assign display_mode        = disp_mode_q;
    assign display_level       = disp_level_q;
    assign mode_change_pending = pending_q;
    assign error_timeout       = error_q;

endmodule

// File: tb/tb_resize_sequencer.sv
// ----------------------------------------------------------------------------
// tb_resize_sequencer
// Directed and randomized stimulus for resize_sequencer, compared against a
// transaction-level model of the requested and committed configuration.
// ----------------------------------------------------------------------------
module tb_resize_sequencer;

    localparam int DEB  = 4;
    localparam int MAXL = 2;
    localparam int TMO  = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       zoom_in_select;
    logic       zoom_out_select;
    logic       use_block_avg_select;
    logic       key_up_n;
    logic       key_down_n;
    logic       frame_start;
    logic       engine_start;
    logic [1:0] engine_mode;
    logic [1:0] engine_level;
    logic       engine_done;
    logic [1:0] display_mode;
    logic [1:0] display_level;
    logic       mode_change_pending;
    logic       error_timeout;

    int checks = 0;
    int passes = 0;

    int reqLevel = 1;
    int dispMode = 0;
    int dispLevel = 1;

    resize_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_LEVEL(MAXL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .zoom_in_select       (zoom_in_select),
        .zoom_out_select      (zoom_out_select),
        .use_block_avg_select (use_block_avg_select),
        .key_up_n             (key_up_n),
        .key_down_n           (key_down_n),
        .frame_start          (frame_start),
        .engine_start         (engine_start),
        .engine_mode          (engine_mode),
        .engine_level         (engine_level),
        .engine_done          (engine_done),
        .display_mode         (display_mode),
        .display_level        (display_level),
        .mode_change_pending  (mode_change_pending),
        .error_timeout        (error_timeout)
    );

    always #5 clk = ~clk;

    // Requested mode from the switch settings, by the documented priority.
    function automatic int expMode();
        if (zoom_in_select && zoom_out_select) return 0;
        if (zoom_in_select) return 1;
        if (zoom_out_select && use_block_avg_select) return 3;
        if (zoom_out_select) return 2;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input bit zi, input bit zo, input bit avg);
        zoom_in_select       = zi;
        zoom_out_select      = zo;
        use_block_avg_select = avg;
        repeat (6) tick();
    endtask

    task automatic pressKey(input bit up);
        if (up) key_up_n = 1'b0;
        else key_down_n = 1'b0;
        repeat (DEB + 6) tick();
        key_up_n   = 1'b1;
        key_down_n = 1'b1;
        repeat (DEB + 6) tick();
        if (up) reqLevel = (reqLevel + 1 > MAXL) ? MAXL : reqLevel + 1;
        else reqLevel = (reqLevel - 1 < 1) ? 1 : reqLevel - 1;
    endtask

    task automatic pulseFrame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulseDone();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_start"}, engine_start, 0);
        checkOutput({tag, "_emode"}, engine_mode, 0);
        checkOutput({tag, "_elevel"}, engine_level, 1);
        checkOutput({tag, "_dmode"}, display_mode, 0);
        checkOutput({tag, "_dlevel"}, display_level, 1);
        checkOutput({tag, "_pending"}, mode_change_pending, 0);
        checkOutput({tag, "_error"}, error_timeout, 0);
    endtask

    // One full request/commit cycle judged against the model.
    task automatic doJob(input int latency);
        int m;
        int l;
        m = expMode();
        l = reqLevel;
        if (m == dispMode && l == dispLevel) begin
            checkOutput("no_change_pending", mode_change_pending, 0);
            return;
        end
        checkOutput("pending_set", mode_change_pending, 1);
        pulseFrame();
        if (m == 0) begin
            checkOutput("pass_no_start", engine_start, 0);
            checkOutput("pass_dmode", display_mode, 0);
            checkOutput("pass_dlevel", display_level, l);
            checkOutput("pass_pending", mode_change_pending, 0);
            tick();
        end else begin
            checkOutput("job_start", engine_start, 1);
            checkOutput("job_emode", engine_mode, m);
            checkOutput("job_elevel", engine_level, l);
            tick();
            checkOutput("job_start_once", engine_start, 0);
            repeat (latency) tick();
            pulseDone();
            checkOutput("job_dmode", display_mode, m);
            checkOutput("job_dlevel", display_level, l);
            checkOutput("job_pending", mode_change_pending, 0);
            tick();
        end
        dispMode  = m;
        dispLevel = l;
    endtask

    initial begin
        int snapLevel;
        reset                = 1'b1;
        zoom_in_select       = 1'b0;
        zoom_out_select      = 1'b0;
        use_block_avg_select = 1'b0;
        key_up_n             = 1'b1;
        key_down_n           = 1'b1;
        frame_start          = 1'b0;
        engine_done          = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkResetValues("reset");

        $display("[TB] zoom-in job from reset");
        applyStimulus(1, 0, 0);
        doJob(3);

        $display("[TB] conflicting zoom switches");
        applyStimulus(1, 1, 0);
        doJob(2);
        checkOutput("conflict_dmode", display_mode, 0);

        $display("[TB] level keys and glitch");
        repeat (3) pressKey(1'b1);
        key_up_n = 1'b0;
        repeat (2) tick();
        key_up_n = 1'b1;
        repeat (DEB + 6) tick();
        applyStimulus(0, 1, 0);
        doJob(4);
        checkOutput("level_saturated", display_level, 2);
        repeat (3) pressKey(1'b0);
        doJob(1);
        checkOutput("level_floor", display_level, 1);

        $display("[TB] randomized requests");
        for (int i = 0; i < 8; i++) begin
            int act;
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom));
            act = $urandom_range(0, 2);
            if (act == 1) pressKey(1'b1);
            else if (act == 2) pressKey(1'b0);
            doJob($urandom_range(1, 8));
        end

        $display("[TB] request change during run");
        applyStimulus(0, 0, 0);
        doJob(2);
        applyStimulus(1, 0, 0);
        snapLevel = reqLevel;
        checkOutput("snap_pending", mode_change_pending, 1);
        pulseFrame();
        checkOutput("snap_start", engine_start, 1);
        checkOutput("snap_emode", engine_mode, 1);
        tick();
        applyStimulus(0, 1, 1);
        checkOutput("snap_held", engine_mode, 1);
        pulseDone();
        checkOutput("snap_dmode", display_mode, 1);
        checkOutput("snap_dlevel", display_level, snapLevel);
        dispMode  = 1;
        dispLevel = snapLevel;
        repeat (3) tick();
        doJob(2);
        checkOutput("second_job_dmode", display_mode, 3);

        $display("[TB] engine timeout and retry");
        applyStimulus(1, 0, 0);
        pulseFrame();
        checkOutput("tmo_start", engine_start, 1);
        repeat (TMO) tick();
        checkOutput("tmo_not_yet", error_timeout, 0);
        tick();
        checkOutput("tmo_error", error_timeout, 1);
        checkOutput("tmo_dmode", display_mode, 3);
        checkOutput("tmo_dlevel", display_level, dispLevel);
        repeat (4) tick();
        checkOutput("tmo_pending", mode_change_pending, 1);
        pulseFrame();
        checkOutput("retry_start", engine_start, 1);
        checkOutput("retry_emode", engine_mode, 1);
        repeat (4) tick();
        pulseDone();
        checkOutput("retry_dmode", display_mode, 1);
        dispMode = 1;
        tick();

        $display("[TB] stray frame_start and engine_done");
        pulseFrame();
        checkOutput("stray_frame", engine_start, 0);
        pulseDone();
        checkOutput("stray_done_dmode", display_mode, 1);
        checkOutput("stray_error_sticky", error_timeout, 1);

        $display("[TB] reset during run");
        applyStimulus(0, 1, 0);
        pulseFrame();
        checkOutput("rst_job_start", engine_start, 1);
        repeat (3) tick();
        reset                = 1'b1;
        zoom_out_select      = 1'b0;
        tick();
        checkResetValues("rst_mid");
        reset = 1'b0;
        pulseDone();
        checkResetValues("rst_after_done");
        reqLevel  = 1;
        dispMode  = 0;
        dispLevel = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rst_no_start", engine_start, 0);
        end
        checkOutput("rst_dmode_final", display_mode, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
